rom_loader: RTL and testbench
=============================

Name: rom_loader

Overview:
- Writer-side counterpart to the team's combinational lookup ROM.
- Receives a byte stream over a valid/ready handshake and assembles bytes into data_width-bit words.
- Writes each word sequentially into a RAM with the same geometry (addr_width x data_width), so the RAM can then be read like the ROM.
- Used for boot-time or test-time image loading in place of file-based initialisation.

Parameters:
- addr_width, 5, word address width; RAM depth is 2**addr_width.
- data_width, 16, word width in bits; must be a multiple of 8 (elaboration-time assertion).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- start_i  input  1  one-cycle request to begin a load; sampled only in IDLE.
- len_i  input  addr_width+1  number of words to load; sampled with start_i.
- abort_i  input  1  cancel the load in progress.
- byte_i  input  8  stream byte.
- byte_valid_i  input  1  byte_i is valid.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- wr_en_o  output  1  RAM write strobe.
- wr_addr_o  output  addr_width  RAM write address.
- wr_data_o  output  data_width  RAM write data.
- busy_o  output  1  load in progress (any state except IDLE).
- done_o  output  1  one-cycle pulse at the end of a load.
- error_o  output  1  sticky error flag; cleared by the next accepted start_i.

Behaviour:
- Reset (rst_ni low, asynchronous): state=IDLE; all outputs 0; word and byte counters 0; assembly register 0.
- All outputs are registered or decoded from registered state only; no combinational input-to-output paths.
- BPW = data_width/8 bytes per word. Little-endian assembly: byte k of a word lands in bits [8k+7:8k].
- Byte transfer occurs only when byte_valid_i && byte_ready_o. byte_i is ignored otherwise.
- IDLE:
  - byte_ready_o=0.
  - start_i with 1 <= len_i <= 2**addr_width: clear error_o, word_cnt=0, byte_cnt=0, go to COLLECT.
  - start_i with len_i=0: clear error_o, go to DONE. No writes.
  - start_i with len_i > 2**addr_width: set error_o=1, go to DONE. No writes.
- COLLECT:
  - byte_ready_o=1.
  - On each transfer, store the byte at slot byte_cnt and increment byte_cnt.
  - On the transfer with byte_cnt==BPW-1: byte_cnt=0, go to WRITE.
- WRITE (exactly one cycle):
  - wr_en_o=1, wr_addr_o=word_cnt, wr_data_o=assembled word; byte_ready_o=0.
  - If word_cnt==len-1, go to DONE; else word_cnt++ and go to COLLECT.
- DONE (one cycle): done_o=1, then go to IDLE.
- wr_addr_o and wr_data_o hold their last values when wr_en_o=0.
- Throughput: one word per BPW+1 cycles at best. No write occurs before the final byte of a word is accepted.
- Simultaneous events:
  - start_i while busy_o=1 is ignored.
  - abort_i has priority over every other event in every non-IDLE state: go to IDLE, set error_o=1, wr_en_o=0, no done_o pulse.
  - abort_i in IDLE is ignored.
  - An abort in the same cycle as the last byte's transfer discards that byte and produces no write.
- Partial words are never written. Words already written before an abort remain in the RAM.
- A reset mid-load behaves as power-on reset; the RAM contents are undefined from the loader's point of view.
- len_i is latched at start; later changes to len_i have no effect on the running load.

Decomposition:
- Package rom_pkg holds:
  - typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} loader_state_t;
  - localparam BYTE_W = 8;
  - function bpw(data_width) returning data_width/BYTE_W.
- Single module; no sub-module is needed.
- The bench instantiates a simple behavioural RAM plus the existing ROM-read model to check contents.

Test Plan:
- Basic load: defaults, len_i=2, bytes 0x34,0x12,0x78,0x56 with valid held high -> writes addr0=0x1234, then addr1=0x5678; done_o pulses once; error_o=0; 8 cycles from start to done inclusive.
- Backpressure: same stream with byte_valid_i toggled every other cycle -> identical writes; no byte lost or duplicated; wr_en_o never high in a cycle where byte_ready_o is high.
- Bounds: len_i=32 -> 32 writes at addrs 0..31, done_o pulses. len_i=33 -> error_o=1, done_o pulses, zero writes. len_i=0 -> done_o pulses, zero writes, error_o=0.
- Abort: abort_i after 3 of 4 bytes -> one write (addr0) only; IDLE next cycle; error_o=1; no done_o. A following valid start clears error_o.
- Reset mid-load: drive rst_ni low while in COLLECT -> all outputs 0 immediately (asynchronously); after release, state is IDLE and ignores bytes.
- Busy start: pulse start_i during COLLECT with a different len_i -> ignored; the original load completes with its original length.

Source files
------------

// File: rtl/rom_pkg.sv
// Shared types and helpers for the ROM image loader.
package rom_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} loader_state_t;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned bpw(input int unsigned data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream, control and RAM-write signals of the ROM image loader.
interface rom_loader_if
  import rom_pkg::*;
#(
  parameter int unsigned addr_width = 5,
  parameter int unsigned data_width = 16
);

  logic                  start_i;
  logic [addr_width:0]   len_i;
  logic                  abort_i;
  logic [BYTE_W-1:0]     byte_i;
  logic                  byte_valid_i;
  logic                  byte_ready_o;
  logic                  wr_en_o;
  logic [addr_width-1:0] wr_addr_o;
  logic [data_width-1:0] wr_data_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  error_o;

  modport master (
    output start_i, len_i, abort_i, byte_i, byte_valid_i,
    input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, error_o
  );

  modport slave (
    input  start_i, len_i, abort_i, byte_i, byte_valid_i,
    output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, error_o
  );

endinterface

// File: rtl/rom_loader.sv
// Assembles a little-endian byte stream into words and writes them
// sequentially into a RAM shaped like the lookup ROM.
module rom_loader
  import rom_pkg::*;
#(
  parameter int unsigned addr_width = 5,
  parameter int unsigned data_width = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  rom_loader_if.slave  bus
);

  localparam int unsigned BPW = bpw(data_width);
  localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BCW-1:0]      LAST_BYTE = BCW'(BPW - 1);
  localparam logic [addr_width:0] MAX_LEN   = {1'b1, {addr_width{1'b0}}};

  if (data_width == 0 || (data_width % BYTE_W) != 0) begin : g_width_check
    $error("rom_loader: data_width must be a non-zero multiple of 8");
  end

  loader_state_t         state_q, state_d;
  logic [addr_width-1:0] word_cnt_q, word_cnt_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [addr_width:0]   len_q, len_d;
  logic [data_width-1:0] asm_q, asm_d;
  logic [addr_width-1:0] wr_addr_q, wr_addr_d;
  logic [data_width-1:0] wr_data_q, wr_data_d;
  logic                  error_q, error_d;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    asm_d      = asm_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    error_d    = error_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          error_d    = 1'b0;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          len_d      = bus.len_i;
          if (bus.len_i == '0) begin
            state_d = DONE;
          end else if (bus.len_i > MAX_LEN) begin
            error_d = 1'b1;
            state_d = DONE;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (bus.byte_valid_i) begin
          asm_d[byte_cnt_q*BYTE_W +: BYTE_W] = bus.byte_i;
          if (byte_cnt_q == LAST_BYTE) begin
            // Capture the finished word so the write bus holds it afterwards.
            byte_cnt_d = '0;
            wr_addr_d  = word_cnt_q;
            wr_data_d  = asm_d;
            state_d    = WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        if ({1'b0, word_cnt_q} == len_q - 1'b1) begin
          state_d = DONE;
        end else begin
          word_cnt_d = word_cnt_q + 1'b1;
          state_d    = COLLECT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a final byte arriving this cycle.
    if (bus.abort_i && state_q != IDLE) begin
      state_d    = IDLE;
      error_d    = 1'b1;
      byte_cnt_d = '0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      asm_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      asm_q      <= asm_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      error_q    <= error_d;
    end
  end

  assign bus.byte_ready_o = (state_q == COLLECT);
  assign bus.wr_en_o      = (state_q == WRITE);
  assign bus.wr_addr_o    = wr_addr_q;
  assign bus.wr_data_o    = wr_data_q;
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.done_o       = (state_q == DONE);
  assign bus.error_o      = error_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed-plus-random bench for rom_loader with a behavioural RAM and ROM-read model.
module tb_rom_loader;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 16;
  localparam int          BPW   = DW / 8;
  localparam int          DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rom_loader_if #(.addr_width(AW), .data_width(DW)) bus ();

  rom_loader #(.addr_width(AW), .data_width(DW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic [DW-1:0] ram [DEPTH];
  wr_t           wlog [$];
  logic [7:0]    stim [$];
  int            cyc       = 0;
  int            done_cnt  = 0;
  int            done_cyc  = 0;
  int            overlap   = 0;
  int            start_cyc = 0;
  int            done_base = 0;
  int            checks    = 0;
  int            errors    = 0;

  always @(posedge clk) begin
    cyc++;
    if (bus.wr_en_o === 1'b1) begin
      ram[bus.wr_addr_o] = bus.wr_data_o;
      wlog.push_back({bus.wr_addr_o, bus.wr_data_o});
      if (bus.byte_ready_o === 1'b1) overlap++;
    end
    if (bus.done_o === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [DW-1:0] rom_read(input logic [AW-1:0] a);
    return ram[a];
  endfunction

  // Expected word w: bytes w*BPW .. w*BPW+BPW-1 of the stream, little-endian.
  function automatic logic [DW-1:0] word_of(input int w);
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < BPW; k++) v = v + (DW'(stim[w*BPW + k]) << (8 * k));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_stim(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom_range(0, 255)));
  endtask

  // Runs one load. abort_at: number of accepted bytes after which abort_i is
  // raised (-1: never); abort_with_byte offers the next byte in that cycle.
  // bs_at: accepted-byte count at which a stray start_i is pulsed (-1: never).
  task automatic load(input int len, input int nbytes, input bit bp,
                      input int abort_at, input bit abort_with_byte, input int bs_at);
    int sent  = 0;
    int guard = 0;
    bit tog   = 1'b0;
    bit xfer;
    bit aborted = 1'b0;
    logic [AW:0] len_v;
    len_v = len[AW:0];
    wlog.delete();
    done_base = done_cnt;
    bus.start_i = 1'b1;
    bus.len_i   = len_v;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    start_cyc   = cyc;
    chk("err_at_start", 64'(bus.error_o), 64'(len > DEPTH));
    while (sent < nbytes && guard < 4000) begin
      guard++;
      tog = ~tog;
      bus.byte_i       = stim[sent];
      bus.byte_valid_i = bp ? tog : 1'b1;
      if (sent == bs_at) begin
        bus.start_i = 1'b1;
        bus.len_i   = 6'd1;
      end
      if (sent == abort_at) begin
        bus.abort_i      = 1'b1;
        bus.byte_valid_i = abort_with_byte;
      end
      xfer = bus.byte_valid_i && bus.byte_ready_o;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      if (sent == abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (xfer) sent++;
    end
    bus.byte_valid_i = 1'b0;
    chk("feed_budget", 64'(guard < 4000), 64'd1);
    if (aborted) chk("abort_idle", 64'(bus.busy_o), 64'd0);
    guard = 0;
    while (bus.busy_o === 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("idle_budget", 64'(bus.busy_o), 64'd0);
  endtask

  task automatic expect_load(input string tag, input int n_exp, input bit err_exp, input int done_exp);
    chk({tag, "_nwr"}, 64'(wlog.size()), 64'(n_exp));
    for (int i = 0; i < n_exp && i < wlog.size(); i++) begin
      chk({tag, "_addr"}, 64'(wlog[i].addr), 64'(i));
      chk({tag, "_data"}, 64'(wlog[i].data), 64'(word_of(i)));
      chk({tag, "_rom"},  64'(rom_read(AW'(i))), 64'(word_of(i)));
    end
    chk({tag, "_done"}, 64'(done_cnt - done_base), 64'(done_exp));
    chk({tag, "_err"},  64'(bus.error_o), 64'(err_exp));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(bus.byte_ready_o), 64'd0);
    chk({tag, "_wren"},  64'(bus.wr_en_o), 64'd0);
    chk({tag, "_addr"},  64'(bus.wr_addr_o), 64'd0);
    chk({tag, "_data"},  64'(bus.wr_data_o), 64'd0);
    chk({tag, "_busy"},  64'(bus.busy_o), 64'd0);
    chk({tag, "_done"},  64'(bus.done_o), 64'd0);
    chk({tag, "_err"},   64'(bus.error_o), 64'd0);
  endtask

  initial begin
    bus.start_i      = 1'b0;
    bus.len_i        = '0;
    bus.abort_i      = 1'b0;
    bus.byte_i       = '0;
    bus.byte_valid_i = 1'b0;
    #1 rst_n = 1'b0;
    #10;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic load with valid held high
    stim = '{8'h34, 8'h12, 8'h78, 8'h56};
    load(2, 4, 1'b0, -1, 1'b0, -1);
    expect_load("basic", 2, 1'b0, 1);
    chk("basic_w0", 64'(wlog[0].data), 64'h1234);
    chk("basic_w1", 64'(wlog[1].data), 64'h5678);
    chk("basic_latency", 64'(done_cyc - start_cyc), 64'd7);

    // Same stream under backpressure
    load(2, 4, 1'b1, -1, 1'b0, -1);
    expect_load("bp", 2, 1'b0, 1);

    // Random lengths and data
    for (int r = 0; r < 4; r++) begin
      int len;
      bit bp;
      len = $urandom_range(1, 8);
      bp  = 1'($urandom_range(0, 1));
      fill_stim(len * BPW);
      load(len, len * BPW, bp, -1, 1'b0, -1);
      expect_load("rand", len, 1'b0, 1);
    end

    // Bounds
    fill_stim(DEPTH * BPW);
    load(DEPTH, DEPTH * BPW, 1'b0, -1, 1'b0, -1);
    expect_load("full", DEPTH, 1'b0, 1);
    load(DEPTH + 1, 0, 1'b0, -1, 1'b0, -1);
    expect_load("over", 0, 1'b1, 1);
    load(0, 0, 1'b0, -1, 1'b0, -1);
    expect_load("zero", 0, 1'b0, 1);

    // Abort after three of four bytes
    fill_stim(4);
    load(2, 4, 1'b0, 3, 1'b0, -1);
    expect_load("abort", 1, 1'b1, 0);

    // Valid start clears the error; load completes normally
    fill_stim(4);
    load(2, 4, 1'b1, -1, 1'b0, -1);
    expect_load("after_abort", 2, 1'b0, 1);

    // Abort coincident with the final byte of a word discards it
    fill_stim(4);
    load(2, 4, 1'b0, 3, 1'b1, -1);
    expect_load("abort_last", 1, 1'b1, 0);

    // Start pulse with a different length while busy is ignored
    fill_stim(6);
    load(3, 6, 1'b0, -1, 1'b0, 1);
    expect_load("busy_start", 3, 1'b0, 1);

    // Asynchronous reset during COLLECT
    fill_stim(4);
    bus.start_i = 1'b1;
    bus.len_i   = 6'd2;
    @(posedge clk); #1;
    bus.start_i      = 1'b0;
    bus.byte_i       = stim[0];
    bus.byte_valid_i = 1'b1;
    @(posedge clk); #1;
    chk("prereset_busy", 64'(bus.busy_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      bus.byte_i = stim[i];
      @(posedge clk); #1;
    end
    bus.byte_valid_i = 1'b0;
    chk("postreset_nwr", 64'(wlog.size()), 64'd0);
    chk("postreset_busy", 64'(bus.busy_o), 64'd0);
    chk("postreset_ready", 64'(bus.byte_ready_o), 64'd0);

    chk("wren_ready_overlap", 64'(overlap), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
